// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decoder handshake.
// master = fetch stage, slave = memory/decoder side.
interface instr_fetch_if #(
    parameter int AW = 10
);
    logic          imem_rd;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   r_in;
    logic [AW-1:0] r_pc;
    logic          r_valid;
    logic          r_ready;
    logic          halt_req;

    modport master (
        output imem_rd, imem_addr, r_in, r_pc, r_valid,
        input  imem_rdata, r_ready, halt_req
    );

    modport slave (
        input  imem_rd, imem_addr, r_in, r_pc, r_valid,
        output imem_rdata, r_ready, halt_req
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, 2-entry prefetch buffer, interrupt-wait parking.
// Optional delivered-instruction counter enabled by defining FETCH_CNT_EN.
module instr_fetch #(
    parameter int AW       = 10,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic          irq,
    output logic          busy,
    output logic [31:0]   instr_cnt,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT_INT} state_t;

    localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);
    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pc, r_end, r_infl_addr;
    logic          r_done, r_infl;
    logic [1:0]    r_count;
    logic          r_wptr, r_rptr;
    logic [31:0]   r_fifo_dat [2];
    logic [AW-1:0] r_fifo_adr [2];

    logic          w_valid, w_pop, w_halt, w_push, w_issue, w_start_acc;
    logic [1:0]    w_occ;
    logic [AW-1:0] w_head_adr;

    assign w_valid     = (r_count != 2'd0);
    assign w_head_adr  = r_fifo_adr[r_rptr];
    assign w_pop       = w_valid & bus.r_ready;
    assign w_halt      = w_pop & bus.halt_req;
    assign w_push      = r_infl & ~w_halt;
    assign w_start_acc = (r_state == S_IDLE) & start;
    // Occupancy after this cycle's pop: counting the pop keeps 1 instr/cycle when streaming.
    assign w_occ       = r_count + {1'b0, r_infl} - {1'b0, w_pop};
    assign w_issue     = (r_state == S_FETCH) & ~r_done & ~w_halt & (w_occ < 2'd2);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (w_halt)
                    w_state_nxt = (w_head_adr == r_end) ? S_IDLE : S_WAIT_INT;
                else if (r_done && (w_occ == 2'd0))
                    w_state_nxt = S_IDLE;
            end
            S_WAIT_INT: begin
                if (irq) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= PC_RST;
            r_done  <= 1'b0;
            r_infl  <= 1'b0;
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_pc   <= start_addr;
                r_done <= 1'b0;
            end else if (w_halt) begin
                r_pc   <= w_head_adr + PC_ONE;
                r_done <= 1'b0;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_ONE;
                if (r_pc == r_end) r_done <= 1'b1;
            end
            if (w_halt) begin
                r_count <= 2'd0;
                r_infl  <= 1'b0;
                r_wptr  <= 1'b0;
                r_rptr  <= 1'b0;
            end else begin
                r_count <= w_occ;
                r_infl  <= w_issue;
                if (w_push) r_wptr <= ~r_wptr;
                if (w_pop)  r_rptr <= ~r_rptr;
            end
        end
    end

    // Data path: no reset needed, occupancy and in-flight flags qualify every entry.
    always_ff @(posedge clk) begin
        if (w_start_acc) r_end <= end_addr;
        if (w_issue)     r_infl_addr <= r_pc;
        if (w_push) begin
            r_fifo_dat[r_wptr] <= bus.imem_rdata;
            r_fifo_adr[r_wptr] <= r_infl_addr;
        end
    end

    assign bus.imem_rd   = w_issue;
    assign bus.imem_addr = r_pc;
    assign bus.r_valid   = w_valid;
    assign bus.r_in      = w_valid ? r_fifo_dat[r_rptr] : 32'd0;
    assign bus.r_pc      = w_valid ? w_head_adr : '0;
    assign busy          = (r_state != S_IDLE) | w_valid;

`ifdef FETCH_CNT_EN
    logic [31:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) r_cnt <= 32'd0;
        else if (w_pop)         r_cnt <= r_cnt + 32'd1;
    end
    assign instr_cnt = r_cnt;
`else
    assign instr_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed plan scenarios plus randomized traffic checked
// against a transaction-level model (expected instruction queue + fetch window).
module tb_instr_fetch;
    localparam int AW = 10;
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2;
`ifdef FETCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} ent_t;

    logic          clk = 1'b0;
    logic          rst, start, irq, busy;
    logic [AW-1:0] start_addr, end_addr;
    logic [31:0]   instr_cnt;
    logic [31:0]   mem [1024];

    instr_fetch_if #(.AW(AW)) ifc ();

    instr_fetch #(.AW(AW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .irq(irq), .busy(busy), .instr_cnt(instr_cnt),
        .bus(ifc.master)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: one cycle read latency.
    always @(posedge clk) if (ifc.imem_rd) ifc.imem_rdata <= mem[ifc.imem_addr];

    int n_checks = 0, n_fail = 0;
    bit chk_en = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: instructions still owed to the decoder, and the window of addresses still to fetch.
    ent_t          q[$];
    int            mode = M_IDLE;
    int            rd_left = 0;
    logic [AW-1:0] rd_next = '0;
    int unsigned   m_cnt = 0;

    always @(negedge clk) begin : cmp
        bit hs;
        ent_t h;
        logic [AW-1:0] a;
        #3;
        if (chk_en) begin
            hs = ifc.r_valid && ifc.r_ready;
            check("busy", busy, (mode != M_IDLE));
            check("instr_cnt", instr_cnt, m_cnt);
            if (ifc.r_valid) begin
                check("valid_ctx", (mode == M_RUN && q.size() > 0), 1);
                if (q.size() > 0) begin
                    check("r_pc", ifc.r_pc, q[0].a);
                    check("r_in", ifc.r_in, q[0].d);
                end
            end
            if (ifc.imem_rd) begin
                check("rd_ctx", (mode == M_RUN && rd_left > 0 && !(hs && ifc.halt_req)), 1);
                check("rd_addr", ifc.imem_addr, rd_next);
                rd_next = rd_next + 10'd1;
                if (rd_left > 0) rd_left--;
            end
            if (rst) begin
                mode = M_IDLE; q.delete(); rd_left = 0; m_cnt = 0;
            end else if (mode == M_IDLE) begin
                if (start) begin
                    q.delete();
                    a = start_addr;
                    for (int k = 0; k < 1024; k++) begin
                        q.push_back({a, mem[a]});
                        if (a == end_addr) break;
                        a = a + 10'd1;
                    end
                    rd_next = start_addr;
                    rd_left = q.size();
                    m_cnt = 0;
                    mode = M_RUN;
                end
            end else if (mode == M_WAIT) begin
                if (irq) mode = M_RUN;
            end else if (hs && q.size() > 0) begin
                h = q.pop_front();
                if (CNT_EN) m_cnt++;
                if (ifc.halt_req) begin
                    rd_next = h.a + 10'd1;
                    rd_left = q.size();
                    mode = (q.size() > 0) ? M_WAIT : M_IDLE;
                end else if (q.size() == 0) begin
                    mode = M_IDLE;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && (busy || mode != M_IDLE); k++) cyc();
        check("idle_reached", busy, 0);
        check("model_idle", mode, M_IDLE);
    endtask

    task automatic go(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        start_addr = sa; end_addr = ea; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] pcs [8];
        logic [AW-1:0] exp_w [4];
        int n, rds;
        bit found, done_f;

        rst = 1'b1; start = 1'b0; irq = 1'b0; start_addr = '0; end_addr = '0;
        ifc.r_ready = 1'b0; ifc.halt_req = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 6; i++) mem[i] = 32'h4C0000A1 + 32'(i);
        mem[10'h3FE] = 32'h4C0000FE; mem[10'h3FF] = 32'h4C0000FF;

        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_r_valid", ifc.r_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_imem_rd", ifc.imem_rd, 0);
        check("rst_imem_addr", ifc.imem_addr, 0);
        check("rst_r_in", ifc.r_in, 0);
        check("rst_r_pc", ifc.r_pc, 0);
        check("rst_instr_cnt", instr_cnt, 0);
        @(posedge clk); #1; rst = 1'b0;
        cyc();

        // Streaming: first valid two edges after start, then one per cycle.
        ifc.r_ready = 1'b1;
        go(10'h000, 10'h003);
        @(negedge clk); check("lat_e0_valid", ifc.r_valid, 0);
        cyc(); @(negedge clk); check("lat_e1_valid", ifc.r_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(); @(negedge clk);
            check("stream_valid", ifc.r_valid, 1);
            check("stream_r_in", ifc.r_in, 32'h4C0000A1 + 32'(i));
            check("stream_r_pc", ifc.r_pc, i);
        end
        cyc(); @(negedge clk);
        check("stream_end_busy", busy, 0);
        check("stream_end_valid", ifc.r_valid, 0);
        check("cnt_after_stream", instr_cnt, CNT_EN ? 4 : 0);
        @(posedge clk); #1;

        go(10'h000, 10'h003);
        @(negedge clk); check("cnt_cleared_by_start", instr_cnt, 0);
        @(posedge clk); #1;
        wait_idle(40);

        // Backpressure: decoder stalls, only two reads may be outstanding.
        ifc.r_ready = 1'b0;
        rds = 0;
        go(10'h000, 10'h003);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (ifc.imem_rd) rds++;
            if (k >= 2) check("bp_r_in_held", ifc.r_in, 32'h4C0000A1);
            @(posedge clk); #1;
        end
        check("bp_reads", rds, 2);
        ifc.r_ready = 1'b1;
        wait_idle(40);

        // Interrupt wait: halt on the instruction at 0x002, release with irq.
        go(10'h000, 10'h005);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (ifc.r_valid && ifc.r_pc == 10'h002) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("halt_target_seen", found, 1);
        if (found) begin
            #1 ifc.halt_req = 1'b1;
            @(posedge clk); #1; ifc.halt_req = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wait_no_valid", ifc.r_valid, 0);
            check("wait_no_rd", ifc.imem_rd, 0);
            @(posedge clk); #1;
        end
        irq = 1'b1; cyc(); irq = 1'b0;
        @(negedge clk);
        check("resume_rd", ifc.imem_rd, 1);
        check("resume_addr", ifc.imem_addr, 10'h003);
        @(posedge clk); #1;
        wait_idle(40);

        // Wrap through the top of the address space.
        exp_w[0] = 10'h3FE; exp_w[1] = 10'h3FF; exp_w[2] = 10'h000; exp_w[3] = 10'h001;
        n = 0; done_f = 1'b0;
        go(10'h3FE, 10'h001);
        for (int k = 0; k < 30 && !done_f; k++) begin
            @(negedge clk);
            if (ifc.r_valid && n < 8) begin pcs[n] = ifc.r_pc; n++; end
            done_f = !busy;
            @(posedge clk); #1;
        end
        check("wrap_count", n, 4);
        for (int i = 0; i < 4; i++) check("wrap_pc", pcs[i], exp_w[i]);
        wait_idle(40);

        // Reset mid-run: one entry buffered and one read in flight.
        ifc.r_ready = 1'b0;
        go(10'h000, 10'h005);
        cyc(); cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstmid_valid", ifc.r_valid, 0);
            check("rstmid_busy", busy, 0);
            check("rstmid_cnt", instr_cnt, 0);
            @(posedge clk); #1;
        end

        // Randomized traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            ifc.r_ready  = ($urandom_range(0, 9) < 7);
            ifc.halt_req = ($urandom_range(0, 9) == 0);
            irq          = ($urandom_range(0, 3) == 0);
            start        = ($urandom_range(0, 5) == 0);
            start_addr   = AW'($urandom_range(0, 1023));
            end_addr     = start_addr + AW'($urandom_range(0, 11));
            cyc();
        end
        rst = 1'b0; start = 1'b0; ifc.halt_req = 1'b0; ifc.r_ready = 1'b1; irq = 1'b1;
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
